// File: rtl/x74xx_pkg.sv
// Shared definitions for the x74xx scan multiplexer: scan FSM state type and
// the state constants used by the top-level sequencer.
package x74xx_pkg;

  localparam int SCAN_STATE_W = 2;

  typedef logic [SCAN_STATE_W-1:0] scan_state_t;

  localparam scan_state_t SCAN_IDLE = 2'd0;
  localparam scan_state_t SCAN_RUN  = 2'd1;
  localparam scan_state_t SCAN_DONE = 2'd2;

endpackage

// File: rtl/x74xx_mux_slice.sv
// One mux channel: INPUTS-wide combinational select gated by an active-low
// enable. Select codes with no matching input produce 0.
module x74xx_mux_slice #(
  parameter  int INPUTS = 4,
  localparam int SEL_W  = $clog2(INPUTS)
) (
  input  logic              en_n,
  input  logic [INPUTS-1:0] din,
  input  logic [SEL_W-1:0]  sel,
  output logic              y
);

  // Decode by equality so out-of-range codes fall through to 0 instead of indexing past din
  always_comb begin
    y = 1'b0;
    for (int k = 0; k < INPUTS; k++) begin
      if (sel == SEL_W'(k)) begin
        y = din[k];
      end
    end
    if (en_n) begin
      y = 1'b0;
    end
  end

endmodule

// File: rtl/x74xx_scan_mux.sv
// Multi-channel registered mux with a shared select that is either latched
// from S (direct mode) or stepped through every input by a scan sequencer.
// The select chosen on an edge is the one used for that edge's sample, so Y
// follows an input or select change with a single cycle of latency.
module x74xx_scan_mux #(
  parameter  int CHANNELS = 2,
  parameter  int INPUTS   = 4,
  localparam int SEL_W    = $clog2(INPUTS)
) (
  input  logic                       clock_50,
  input  logic                       reset_n,
  input  logic [CHANNELS-1:0]        E_N,
  input  logic [CHANNELS*INPUTS-1:0] I,
  input  logic [SEL_W-1:0]           S,
  input  logic                       SEL_LE,
  input  logic                       MODE,
  input  logic                       SCAN_START,
  output logic [CHANNELS-1:0]        Y,
  output logic                       Y_VALID,
  output logic [SEL_W-1:0]           SEL_OUT,
  output logic                       SCAN_BUSY,
  output logic                       SCAN_DONE
);

  import x74xx_pkg::*;

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(INPUTS - 1);

  scan_state_t         state_reg, state_next;
  logic [SEL_W-1:0]    sel_reg, sel_next;
  logic                sample_next;
  logic [CHANNELS-1:0] mux_y;
  logic [CHANNELS-1:0] y_reg;
  logic                y_valid_reg;
  logic [SEL_W-1:0]    sel_out_reg;

  // Per-channel select logic, all channels driven by the select being loaded this edge
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_slice
    x74xx_mux_slice #(
      .INPUTS(INPUTS)
    ) u_slice (
      .en_n(E_N[gi]),
      .din (I[gi*INPUTS +: INPUTS]),
      .sel (sel_next),
      .y   (mux_y[gi])
    );
  end

  // Sequencer: next state, next select, and whether this edge captures a sample
  always_comb begin
    state_next  = state_reg;
    sel_next    = sel_reg;
    sample_next = 1'b0;
    case (state_reg)
      SCAN_IDLE: begin
        if (MODE) begin
          if (SCAN_START) begin
            state_next  = SCAN_RUN;
            sel_next    = '0;
            sample_next = 1'b1;
          end
        end else begin
          if (SEL_LE) begin
            sel_next = S;
          end
          sample_next = 1'b1;
        end
      end
      SCAN_RUN: begin
        if (!MODE) begin
          // Leaving scan mode aborts without a completion pulse
          state_next  = SCAN_IDLE;
          sel_next    = '0;
          sample_next = 1'b1;
        end else if (sel_reg == SEL_LAST) begin
          state_next = x74xx_pkg::SCAN_DONE;
        end else begin
          sel_next    = sel_reg + 1'b1;
          sample_next = 1'b1;
        end
      end
      default: begin
        // Completion cycle (and recovery from the unused code): back to idle, select held
        state_next = SCAN_IDLE;
        if (!MODE) begin
          if (SEL_LE) begin
            sel_next = S;
          end
          sample_next = 1'b1;
        end
      end
    endcase
  end

  // FSM state and select register
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= SCAN_IDLE;
      sel_reg   <= '0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
    end
  end

  // Output register: capture on sample edges; otherwise hold, still clearing disabled channels
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      y_reg       <= '0;
      y_valid_reg <= 1'b0;
      sel_out_reg <= '0;
    end else if (sample_next) begin
      y_reg       <= mux_y;
      y_valid_reg <= 1'b1;
      sel_out_reg <= sel_next;
    end else begin
      y_reg       <= y_reg & ~E_N;
      y_valid_reg <= 1'b0;
    end
  end

  assign Y         = y_reg;
  assign Y_VALID   = y_valid_reg;
  assign SEL_OUT   = sel_out_reg;
  assign SCAN_BUSY = (state_reg != SCAN_IDLE);
  assign SCAN_DONE = (state_reg == x74xx_pkg::SCAN_DONE);

endmodule

// File: tb/tb_x74xx_scan_mux.sv
// Bench for x74xx_scan_mux: scoreboard of expected samples fed by a
// behavioural model, directed spec scenarios, randomized traffic, and a
// 3-channel / 5-input instance for the non-power-of-two case.
module tb_x74xx_scan_mux;

  localparam int CH  = 2;
  localparam int IN  = 4;
  localparam int SW  = 2;
  localparam int CH5 = 3;
  localparam int IN5 = 5;
  localparam int SW5 = 3;

  logic clock_50 = 1'b0;
  logic reset_n  = 1'b0;

  logic [CH-1:0]    e_n;
  logic [CH*IN-1:0] din;
  logic [SW-1:0]    s;
  logic             sel_le, mode, scan_start;
  logic [CH-1:0]    y;
  logic             y_valid;
  logic [SW-1:0]    sel_out;
  logic             scan_busy, scan_done;

  logic [CH5-1:0]     e_n5;
  logic [CH5*IN5-1:0] din5;
  logic [SW5-1:0]     s5;
  logic               sel_le5, mode5, scan_start5;
  logic [CH5-1:0]     y5;
  logic               y_valid5;
  logic [SW5-1:0]     sel_out5;
  logic               scan_busy5, scan_done5;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int            sel;
    logic [CH-1:0] y;
  } sample_t;

  sample_t sb_q[$];

  // Behavioural model state: phase 0 idle, 1 scanning, 2 completion cycle
  int            m_phase = 0;
  int            m_next  = 0;
  int            m_sel   = 0;
  logic [CH-1:0] m_y     = '0;
  logic          exp_valid = 1'b0;
  logic          exp_busy  = 1'b0;
  logic          exp_done  = 1'b0;

  always #10 clock_50 = ~clock_50;

  x74xx_scan_mux #(.CHANNELS(CH), .INPUTS(IN)) u_dut (
    .clock_50  (clock_50),
    .reset_n   (reset_n),
    .E_N       (e_n),
    .I         (din),
    .S         (s),
    .SEL_LE    (sel_le),
    .MODE      (mode),
    .SCAN_START(scan_start),
    .Y         (y),
    .Y_VALID   (y_valid),
    .SEL_OUT   (sel_out),
    .SCAN_BUSY (scan_busy),
    .SCAN_DONE (scan_done)
  );

  x74xx_scan_mux #(.CHANNELS(CH5), .INPUTS(IN5)) u_dut5 (
    .clock_50  (clock_50),
    .reset_n   (reset_n),
    .E_N       (e_n5),
    .I         (din5),
    .S         (s5),
    .SEL_LE    (sel_le5),
    .MODE      (mode5),
    .SCAN_START(scan_start5),
    .Y         (y5),
    .Y_VALID   (y_valid5),
    .SEL_OUT   (sel_out5),
    .SCAN_BUSY (scan_busy5),
    .SCAN_DONE (scan_done5)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference mux: bit c is input (c, idx) of the flat bus when enabled and idx exists
  function automatic logic [CH-1:0] ref_mux(input logic [CH*IN-1:0] v,
                                            input logic [CH-1:0] en_n, input int idx);
    logic [CH-1:0] r;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      if (!en_n[c] && idx < IN) r[c] = v[c*IN + idx];
    end
    return r;
  endfunction

  // Predict what the coming rising edge does, push any sample onto the scoreboard
  task automatic model_edge();
    int idx;
    bit take;
    idx  = 0;
    take = 0;
    case (m_phase)
      0: begin
        if (mode) begin
          if (scan_start) begin
            idx = 0; take = 1; m_next = 1; m_phase = 1;
          end
        end else begin
          if (sel_le) m_sel = int'(s);
          idx = m_sel; take = 1;
        end
      end
      1: begin
        if (!mode) begin
          m_phase = 0; idx = 0; take = 1;
        end else if (m_next == IN) begin
          m_phase = 2;
        end else begin
          idx = m_next; m_next++; take = 1;
        end
      end
      default: begin
        m_phase = 0;
        if (!mode) begin
          if (sel_le) m_sel = int'(s);
          idx = m_sel; take = 1;
        end
      end
    endcase
    if (take) begin
      m_sel = idx;
      m_y   = ref_mux(din, e_n, idx);
      sb_q.push_back('{idx, m_y});
    end else begin
      m_y = m_y & ~e_n;
    end
    exp_valid = take;
    exp_busy  = (m_phase != 0);
    exp_done  = (m_phase == 2);
  endtask

  // Called at a falling edge with inputs set; returns at the next falling edge
  task automatic tick();
    model_edge();
    @(negedge clock_50);
  endtask

  // Assert reset between edges and confirm outputs clear without a clock
  task automatic do_reset();
    #3;
    reset_n = 1'b0;
    #1;
    check("rst_y", y, '0);
    check("rst_y_valid", y_valid, 1'b0);
    check("rst_sel_out", sel_out, '0);
    check("rst_busy", scan_busy, 1'b0);
    check("rst_done", scan_done, 1'b0);
    check("rst_y5", y5, '0);
    m_phase = 0; m_next = 0; m_sel = 0; m_y = '0;
    sb_q.delete();
    #2;
    reset_n = 1'b1;
  endtask

  // Monitor: per-cycle flag checks, scoreboard pop whenever the DUT presents a sample
  always @(posedge clock_50) begin : monitor
    sample_t e;
    #1;
    if (reset_n) begin
      check("y_valid", y_valid, exp_valid);
      check("scan_busy", scan_busy, exp_busy);
      check("scan_done", scan_done, exp_done);
      if (y_valid) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_underflow: got sample sel=%0d y=%0b expected none", sel_out, y);
        end else begin
          e = sb_q.pop_front();
          check("sb_sel_out", sel_out, e.sel);
          check("sb_y", y, e.y);
        end
      end else if (sb_q.size() != 0) begin
        void'(sb_q.pop_front());
      end
    end
  end

  logic [1:0] scan_sel_tab [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
  logic [1:0] scan_y_tab   [4] = '{2'b01, 2'b00, 2'b00, 2'b10};

  initial begin
    int cnt;
    int done_cnt;
    logic [CH5-1:0] exp5;
    e_n = '0; din = '0; s = '0; sel_le = 1'b0; mode = 1'b0; scan_start = 1'b0;
    e_n5 = '0; din5 = '0; s5 = '0; sel_le5 = 1'b0; mode5 = 1'b0; scan_start5 = 1'b0;
    @(negedge clock_50);
    do_reset();

    // Direct mode: latch S=2 and sample
    sel_le = 1'b1; s = 2'd2; din = 8'b0100_0100;
    tick();
    check("d34_y", y, 2'b11);
    check("d34_sel_out", sel_out, 2);

    // Latch S=1, then hold it while S changes
    s = 2'd1; tick();
    sel_le = 1'b0; s = 2'd3; din = 8'b1101_1101;
    tick();
    check("d35_y", y, 2'b00);
    check("d35_sel_out", sel_out, 1);

    // Enable gating and channel wiring
    sel_le = 1'b1; s = 2'd0; e_n = 2'b01; din = 8'hFF;
    tick();
    check("d36_y_en", y, 2'b10);
    e_n = 2'b00; din = 8'h01;
    tick();
    check("d36_y_wire", y, 2'b01);

    // Full scan with an ignored mid-scan start
    mode = 1'b1; sel_le = 1'b0; din = 8'b1000_0001;
    for (int k = 0; k < 4; k++) begin
      scan_start = (k == 0) || (k == 2);
      tick();
      check("d37_sel_out", sel_out, scan_sel_tab[k]);
      check("d37_y", y, scan_y_tab[k]);
    end
    scan_start = 1'b0;
    tick();
    check("d37_done_pulse", scan_done, 1'b1);
    check("d37_valid_off", y_valid, 1'b0);
    tick();
    check("d37_done_end", scan_done, 1'b0);
    check("d37_idle", scan_busy, 1'b0);
    check("d37_y_hold", y, 2'b10);

    // Reset at scan step 2
    scan_start = 1'b1; tick();
    scan_start = 1'b0; tick();
    do_reset();
    tick();
    check("d38_no_done", scan_done, 1'b0);

    // Abort by leaving scan mode at step 1
    scan_start = 1'b1; tick();
    scan_start = 1'b0; mode = 1'b0; sel_le = 1'b0;
    tick();
    check("d38_abort_busy", scan_busy, 1'b0);
    check("d38_abort_sel", sel_out, 0);
    check("d38_abort_done", scan_done, 1'b0);
    tick();
    check("d38_sel_zero", sel_out, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 249) == 0) do_reset();
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      scan_start = ($urandom_range(0, 5) == 0);
      sel_le     = 1'($urandom_range(0, 1));
      s          = SW'($urandom);
      e_n        = ($urandom_range(0, 3) == 0) ? CH'($urandom) : '0;
      din        = (CH*IN)'($urandom);
      tick();
    end

    // Five-input, three-channel instance
    mode = 1'b0; scan_start = 1'b0;
    sel_le5 = 1'b1; s5 = 3'd7; din5 = '1; e_n5 = '0; mode5 = 1'b0;
    tick();
    check("d39_y_oor", y5, 3'b000);
    check("d39_sel_oor", sel_out5, 7);
    s5 = 3'd4;
    tick();
    check("d39_y_last", y5, 3'b111);
    sel_le5 = 1'b0; mode5 = 1'b1; scan_start5 = 1'b1;
    din5 = 15'((1 << 1) | (1 << 7) | (1 << 13));
    tick();
    scan_start5 = 1'b0;
    cnt = 0;
    done_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (y_valid5) begin
        exp5 = '0;
        if (cnt >= 1 && cnt <= 3) exp5[cnt-1] = 1'b1;
        check("d39_scan_sel", sel_out5, cnt);
        check("d39_scan_y", y5, exp5);
        cnt++;
      end
      if (scan_done5) done_cnt++;
      tick();
    end
    check("d39_valid_count", cnt, 5);
    check("d39_done_count", done_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/x74xx_scan_mux.md
X74XX_SCAN_MUX -- requirements
Module: x74xx_scan_mux

Interface
REQ-001 Parameter CHANNELS, default 2, number of independent mux channels sharing one select; legal range 1..16.
REQ-002 Parameter INPUTS, default 4, data inputs per channel; legal range 2..16, not required to be a power of two.
REQ-003 Parameter SEL_W, default $clog2(INPUTS), select width; localparam, not overridable.
REQ-004 clock_50  in  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 E_N  in  CHANNELS  per-channel active-low enable.
REQ-007 I  in  CHANNELS*INPUTS  data; channel c input k at bit c*INPUTS+k.
REQ-008 S  in  SEL_W  external select.
REQ-009 SEL_LE  in  1  select latch enable; S captured when high.
REQ-010 MODE  in  1  0 = direct (latched select), 1 = auto-scan.
REQ-011 SCAN_START  in  1  single-cycle scan request, honoured only in MODE 1.
REQ-012 Y  out  CHANNELS  registered mux outputs.
REQ-013 Y_VALID  out  1  high the cycle after each scan-step sample; high continuously in MODE 0.
REQ-014 SEL_OUT  out  SEL_W  select index that produced the current Y.
REQ-015 SCAN_BUSY  out  1  high while the scan FSM is not IDLE.
REQ-016 SCAN_DONE  out  1  one-cycle pulse at scan completion.

Function
REQ-017 Y[c] SHALL register (~E_N[c] & I[c*INPUTS+sel]) each cycle; one-cycle latency from any input change to Y.
REQ-018 A disabled channel SHALL drive Y[c]=0 the cycle after E_N[c] rises, independent of other channels.
REQ-019 In MODE 0, sel SHALL load S on clock edges where SEL_LE=1 and hold otherwise.
REQ-020 A select value >= INPUTS SHALL be out of range: affected Y bits SHALL be 0 and sel SHALL still load.
REQ-021 Scan FSM states: IDLE, SCAN, DONE; encoding in shared package.
REQ-022 IDLE->SCAN when MODE=1 and SCAN_START=1; sel set to 0 on the same edge.
REQ-023 In SCAN, sel SHALL increment by 1 per cycle; Y_VALID high the cycle after each sample; SEL_OUT tracks the index sampled.
REQ-024 SCAN->DONE on the edge after sel=INPUTS-1 is sampled; exactly INPUTS samples per scan.
REQ-025 DONE SHALL last one cycle, assert SCAN_DONE, then return to IDLE with sel held at INPUTS-1.
REQ-026 SCAN_START while in SCAN or DONE SHALL be ignored (no restart, no queueing).
REQ-027 MODE 1->0 during SCAN SHALL abort to IDLE next edge, no SCAN_DONE, sel=0.
REQ-028 SEL_LE SHALL be ignored in MODE 1; in IDLE with MODE 1, Y_VALID=0 and Y holds last value.
REQ-029 SCAN_START with MODE=0 SHALL have no effect.

Reset
REQ-030 reset_n low SHALL asynchronously force Y=0, Y_VALID=0, SEL_OUT=0, sel=0, SCAN_BUSY=0, SCAN_DONE=0, FSM=IDLE.
REQ-031 Reset asserted mid-scan SHALL abort immediately with no SCAN_DONE; first capture after release is on the first rising edge.

Structure
REQ-032 FSM state typedef and SCAN_IDLE/SCAN_RUN/SCAN_DONE constants SHALL live in package x74xx_pkg.
REQ-033 One per-channel sub-module, x74xx_mux_slice (INPUTS-wide combinational select with enable), SHALL be instantiated CHANNELS times via generate; sequencing stays in the top.

Verification
REQ-034 Defaults, MODE 0, SEL_LE=1, S=2, E_N=00, I=8'b0100_0100 -> Y=2'b11 one edge later, SEL_OUT=2.
REQ-035 MODE 0, S=1 latched, then SEL_LE=0, S=3, I=8'b1101_1101 -> Y stays 2'b00 (sel held at 1).
REQ-036 E_N=2'b01 with I=8'hFF, sel=0 -> Y=2'b10; cross-wiring check I=8'h01 -> Y=2'b01.
REQ-037 MODE 1, SCAN_START pulse, I=8'b1000_0001 -> Y_VALID 4 cycles, (SEL_OUT,Y) = (0,01),(1,00),(2,00),(3,10); SCAN_DONE one cycle after; second SCAN_START mid-scan ignored.
REQ-038 reset_n low at scan step 2 -> all outputs 0 asynchronously, no SCAN_DONE; MODE 1->0 at step 1 -> IDLE, sel=0, no SCAN_DONE.
REQ-039 INPUTS=5, CHANNELS=3 instance: S=7 -> Y=3'b000; scan yields exactly 5 Y_VALID cycles.
